// File: rtl/safety_boot_sequencer.sv
// Boot-and-monitor master: writes per-core boot address and fetch-enable over a
// single-outstanding register bus, then polls core status until EOC, error or timeout.
module safety_boot_sequencer #(
  parameter int                   AddrWidth        = 32,
  parameter int                   DataWidth        = 32,
  parameter int                   NumCores         = 2,
  parameter logic [AddrWidth-1:0] SocCtrlBase      = 32'h0020_0000,
  parameter logic [AddrWidth-1:0] CoreStride       = 32'h0000_1000,
  parameter logic [AddrWidth-1:0] BootAddrOffset   = 32'h0000_0000,
  parameter logic [AddrWidth-1:0] FetchEnOffset    = 32'h0000_0004,
  parameter logic [AddrWidth-1:0] CoreStatusOffset = 32'h0000_0008,
  parameter int                   PollInterval     = 64,
  parameter int                   TimeoutCycles    = 2**20
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          mode_i,
  input  logic [NumCores-1:0]           core_mask_i,
  input  logic [NumCores*AddrWidth-1:0] boot_addr_i,
  output logic                          req_valid_o,
  input  logic                          req_ready_i,
  output logic [AddrWidth-1:0]          req_addr_o,
  output logic                          req_write_o,
  output logic [DataWidth-1:0]          req_wdata_o,
  input  logic                          rsp_valid_i,
  input  logic [DataWidth-1:0]          rsp_rdata_i,
  input  logic                          rsp_error_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          fail_o,
  output logic [NumCores-1:0]           core_done_o,
  output logic [NumCores*31-1:0]        exit_code_o
);

  localparam int CW = (NumCores > 1) ? $clog2(NumCores) : 1;
  localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int PW = $clog2(PollInterval + 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TimeoutCycles);
  localparam logic [PW-1:0] POLL_LAST = PW'(PollInterval - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_BOOT, S_WR_FETCH, S_WAIT, S_RD_STATUS, S_NEXT, S_FINISH
  } state_t;

  state_t                        r_state;
  logic [CW-1:0]                 r_core;
  logic                          r_mode;
  logic [NumCores-1:0]           r_mask;
  logic [NumCores*AddrWidth-1:0] r_boot;
  logic                          r_req_valid;
  logic [AddrWidth-1:0]          r_req_addr;
  logic                          r_req_write;
  logic [DataWidth-1:0]          r_req_wdata;
  logic                          r_pending;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_fail;
  logic [NumCores-1:0]           r_core_done;
  logic [NumCores*31-1:0]        r_exit;
  logic                          r_tmo_armed;
  logic [TW-1:0]                 r_tmo_cnt;
  logic [PW-1:0]                 r_wait_cnt;

  logic                 w_accept;
  logic                 w_rsp;
  logic                 w_tmo;
  logic                 w_eoc;
  logic [NumCores-1:0]  w_done_set;
  logic [NumCores-1:0]  w_pend;
  logic [CW-1:0]        w_rr;
  logic                 w_has_next;
  logic [CW-1:0]        w_next;
  logic [CW-1:0]        w_first_en;
  logic [CW-1:0]        w_start_core;
  logic [AddrWidth-1:0] w_boot_next;
  logic [AddrWidth-1:0] w_boot_start;

  function automatic logic [AddrWidth-1:0] reg_addr(input logic [CW-1:0] k,
                                                    input logic [AddrWidth-1:0] off);
    return SocCtrlBase + AddrWidth'(k) * CoreStride + off;
  endfunction

  // Lowest set mask bit at or above index 'from'.
  function automatic logic [CW-1:0] first_from(input logic [NumCores-1:0] m, input int from);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = NumCores - 1; i >= 0; i--)
      if (i >= from && m[CW'(i)]) idx = CW'(i);
    return idx;
  endfunction

  function automatic logic any_from(input logic [NumCores-1:0] m, input int from);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NumCores; i++)
      if (i >= from && m[CW'(i)]) hit = 1'b1;
    return hit;
  endfunction

  // Round-robin: first set bit strictly after k, wrapping back to k itself last.
  function automatic logic [CW-1:0] rr_pick(input logic [NumCores-1:0] m, input logic [CW-1:0] k);
    logic [CW-1:0] idx;
    logic          hit;
    int            j;
    idx = k;
    hit = 1'b0;
    for (int i = 1; i <= NumCores; i++) begin
      j = (int'(k) + i) % NumCores;
      if (!hit && m[CW'(j)]) begin
        idx = CW'(j);
        hit = 1'b1;
      end
    end
    return idx;
  endfunction

  always_comb begin
    w_accept     = r_req_valid & req_ready_i;
    w_rsp        = rsp_valid_i & (r_pending | w_accept);
    w_tmo        = (TimeoutCycles != 0) && r_tmo_armed && (r_tmo_cnt == TMO_MAX);
    w_eoc        = rsp_rdata_i[31] & ~rsp_error_i;
    w_done_set   = r_core_done | (w_eoc ? (NumCores'(1) << r_core) : '0);
    w_pend       = r_mask & ~w_done_set;
    w_rr         = rr_pick(w_pend, r_core);
    w_has_next   = any_from(r_mask, int'(r_core) + 1);
    w_next       = first_from(r_mask, int'(r_core) + 1);
    w_first_en   = first_from(r_mask, 0);
    w_start_core = first_from(core_mask_i, 0);
    w_boot_next  = r_boot[int'(w_next)*AddrWidth +: AddrWidth];
    w_boot_start = boot_addr_i[int'(w_start_core)*AddrWidth +: AddrWidth];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_core      <= '0;
      r_mode      <= 1'b0;
      r_mask      <= '0;
      r_boot      <= '0;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_write <= 1'b0;
      r_req_wdata <= '0;
      r_pending   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_core_done <= '0;
      r_exit      <= '0;
      r_tmo_armed <= 1'b0;
      r_tmo_cnt   <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_tmo_armed && r_tmo_cnt != TMO_MAX) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_accept) r_req_valid <= 1'b0;
      if (w_accept && !rsp_valid_i) r_pending <= 1'b1;
      if (w_rsp) r_pending <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_core_done <= '0;
            r_exit      <= '0;
            r_fail      <= 1'b0;
            r_mode      <= mode_i;
            r_mask      <= core_mask_i;
            r_boot      <= boot_addr_i;
            r_tmo_armed <= 1'b0;
            r_tmo_cnt   <= '0;
            if (core_mask_i == '0) begin
              r_done <= 1'b1;
            end else begin
              r_busy      <= 1'b1;
              r_core      <= w_start_core;
              r_req_valid <= 1'b1;
              r_req_write <= 1'b1;
              r_req_addr  <= reg_addr(w_start_core, BootAddrOffset);
              r_req_wdata <= DataWidth'(w_boot_start);
              r_state     <= S_WR_BOOT;
            end
          end
        end

        S_WR_BOOT: begin
          if (w_rsp) begin
            if (rsp_error_i || w_tmo) begin
              r_fail  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_req_valid <= 1'b1;
              r_req_write <= 1'b1;
              r_req_addr  <= reg_addr(r_core, FetchEnOffset);
              r_req_wdata <= DataWidth'(1);
              if (!r_tmo_armed) begin
                r_tmo_armed <= 1'b1;
                r_tmo_cnt   <= '0;
              end
              r_state <= S_WR_FETCH;
            end
          end
        end

        S_WR_FETCH: begin
          if (w_rsp) begin
            if (rsp_error_i || w_tmo) begin
              r_fail  <= 1'b1;
              r_state <= S_FINISH;
            end else if (!r_mode && w_has_next) begin
              r_core      <= w_next;
              r_req_valid <= 1'b1;
              r_req_write <= 1'b1;
              r_req_addr  <= reg_addr(w_next, BootAddrOffset);
              r_req_wdata <= DataWidth'(w_boot_next);
              r_state     <= S_WR_BOOT;
            end else begin
              if (!r_mode) r_core <= w_first_en;
              r_wait_cnt <= '0;
              r_state    <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (w_tmo) begin
            r_fail  <= 1'b1;
            r_state <= S_FINISH;
          end else if (r_wait_cnt == POLL_LAST) begin
            r_req_valid <= 1'b1;
            r_req_write <= 1'b0;
            r_req_addr  <= reg_addr(r_core, CoreStatusOffset);
            r_req_wdata <= '0;
            r_state     <= S_RD_STATUS;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        S_RD_STATUS: begin
          if (w_rsp) begin
            // EOC is recorded even when a timeout lands in the same cycle.
            if (w_eoc) begin
              r_core_done[r_core]           <= 1'b1;
              r_exit[int'(r_core)*31 +: 31] <= rsp_rdata_i[30:0];
              if (rsp_rdata_i[30:0] != '0) r_fail <= 1'b1;
            end
            if (rsp_error_i || w_tmo) begin
              r_fail  <= 1'b1;
              r_state <= S_FINISH;
            end else if (r_mode) begin
              r_wait_cnt <= '0;
              r_state    <= w_eoc ? S_NEXT : S_WAIT;
            end else if (w_pend == '0) begin
              r_state <= S_FINISH;
            end else begin
              r_core     <= w_rr;
              r_wait_cnt <= '0;
              r_state    <= S_WAIT;
            end
          end
        end

        S_NEXT: begin
          if (w_tmo) begin
            r_fail  <= 1'b1;
            r_state <= S_FINISH;
          end else if (w_has_next) begin
            r_core      <= w_next;
            r_req_valid <= 1'b1;
            r_req_write <= 1'b1;
            r_req_addr  <= reg_addr(w_next, BootAddrOffset);
            r_req_wdata <= DataWidth'(w_boot_next);
            r_state     <= S_WR_BOOT;
          end else begin
            r_state <= S_FINISH;
          end
        end

        S_FINISH: begin
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_tmo_armed <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_valid_o = r_req_valid;
  assign req_addr_o  = r_req_addr;
  assign req_write_o = r_req_write;
  assign req_wdata_o = r_req_wdata;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign fail_o      = r_fail;
  assign core_done_o = r_core_done;
  assign exit_code_o = r_exit;

endmodule

// File: tb/tb_safety_boot_sequencer.sv
// Directed bench for safety_boot_sequencer with a zero-latency register-bus responder.
module tb_safety_boot_sequencer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NC = 2;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           start_i;
  logic           mode_i;
  logic [NC-1:0]  core_mask_i;
  logic [NC*AW-1:0] boot_addr_i;
  logic           req_valid_o;
  logic           req_ready_i;
  logic [AW-1:0]  req_addr_o;
  logic           req_write_o;
  logic [DW-1:0]  req_wdata_o;
  logic           rsp_valid_i;
  logic [DW-1:0]  rsp_rdata_i;
  logic           rsp_error_i;
  logic           busy_o;
  logic           done_o;
  logic           fail_o;
  logic [NC-1:0]  core_done_o;
  logic [NC*31-1:0] exit_code_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_wd[$];
  logic        log_we[$];

  int          stall_left = 0;
  int          stall_seen = 0;
  int          unstable   = 0;
  logic        stall_active = 1'b0;
  logic [31:0] sv_addr, sv_wd;
  logic        sv_we;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;
  logic [31:0] status_val [NC];

  safety_boot_sequencer #(
    .AddrWidth(AW), .DataWidth(DW), .NumCores(NC),
    .PollInterval(16), .TimeoutCycles(500)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .core_mask_i(core_mask_i), .boot_addr_i(boot_addr_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .req_write_o(req_write_o), .req_wdata_o(req_wdata_o),
    .rsp_valid_i(rsp_valid_i), .rsp_rdata_i(rsp_rdata_i), .rsp_error_i(rsp_error_i),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
    .core_done_o(core_done_o), .exit_code_o(exit_code_o)
  );

  always #5 clk_i = ~clk_i;

  // Responder: accepts and answers in the same cycle unless a stall is pending.
  initial begin
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_error_i = 1'b0;
    rsp_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      req_ready_i = 1'b0;
      rsp_valid_i = 1'b0;
      rsp_error_i = 1'b0;
      rsp_rdata_i = '0;
      if (req_valid_o) begin
        if (stall_left > 0) begin
          if (!stall_active) begin
            sv_addr = req_addr_o;
            sv_wd   = req_wdata_o;
            sv_we   = req_write_o;
            stall_active = 1'b1;
          end else if (req_addr_o != sv_addr || req_wdata_o != sv_wd || req_write_o != sv_we) begin
            unstable++;
          end
          stall_seen++;
          stall_left--;
        end else begin
          if (stall_active) begin
            if (req_addr_o != sv_addr || req_wdata_o != sv_wd || req_write_o != sv_we) unstable++;
            stall_active = 1'b0;
          end
          req_ready_i = 1'b1;
          rsp_valid_i = 1'b1;
          log_addr.push_back(req_addr_o);
          log_wd.push_back(req_wdata_o);
          log_we.push_back(req_write_o);
          if (req_write_o && err_en && req_addr_o == err_addr) rsp_error_i = 1'b1;
          if (!req_write_o) rsp_rdata_i = status_val[req_addr_o[12]];
        end
      end else if (stall_active) begin
        unstable++;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic start_run(input logic m, input logic [NC-1:0] mask);
    log_addr.delete();
    log_wd.delete();
    log_we.delete();
    @(negedge clk_i);
    mode_i      = m;
    core_mask_i = mask;
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!done_o && cycles < budget) begin
      @(negedge clk_i);
      cycles++;
    end
    check_eq({tag, "_done_seen"}, done_o, 1'b1);
  endtask

  task automatic check_txn(input string tag, input int i, input logic [31:0] a,
                           input logic we, input logic [31:0] wd);
    if (i < log_addr.size()) begin
      check_eq($sformatf("%s_txn%0d_addr", tag, i), log_addr[i], a);
      check_eq($sformatf("%s_txn%0d_we", tag, i), log_we[i], we);
      if (we) check_eq($sformatf("%s_txn%0d_wdata", tag, i), log_wd[i], wd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    mode_i      = 1'b0;
    core_mask_i = '0;
    boot_addr_i = {32'h1C00_0100, 32'h1C00_0080};
    status_val[0] = '0;
    status_val[1] = '0;

    repeat (3) @(negedge clk_i);
    check_eq("rst_busy",      busy_o,      1'b0);
    check_eq("rst_done",      done_o,      1'b0);
    check_eq("rst_fail",      fail_o,      1'b0);
    check_eq("rst_core_done", core_done_o, '0);
    check_eq("rst_exit",      exit_code_o, '0);
    check_eq("rst_req_valid", req_valid_o, 1'b0);
    check_eq("rst_req_addr",  req_addr_o,  '0);
    check_eq("rst_req_wdata", req_wdata_o, '0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Zero mask: immediate done pulse, never busy.
    start_run(1'b0, 2'b00);
    check_eq("zmask_done", done_o, 1'b1);
    check_eq("zmask_busy", busy_o, 1'b0);
    check_eq("zmask_fail", fail_o, 1'b0);
    @(negedge clk_i);
    check_eq("zmask_done_pulse", done_o, 1'b0);
    check_eq("zmask_no_req", log_addr.size(), 0);

    // Mode 0, both cores, clean EOC.
    status_val[0] = 32'h8000_0000;
    status_val[1] = 32'h8000_0000;
    start_run(1'b0, 2'b11);
    check_eq("m0_busy_rise", busy_o, 1'b1);
    wait_done("m0", 600, cyc);
    check_eq("m0_busy_fall", busy_o,      1'b0);
    check_eq("m0_fail",      fail_o,      1'b0);
    check_eq("m0_core_done", core_done_o, 2'b11);
    check_eq("m0_exit",      exit_code_o, '0);
    check_eq("m0_txn_count", log_addr.size(), 6);
    check_txn("m0", 0, 32'h0020_0000, 1'b1, 32'h1C00_0080);
    check_txn("m0", 1, 32'h0020_0004, 1'b1, 32'h0000_0001);
    check_txn("m0", 2, 32'h0020_1000, 1'b1, 32'h1C00_0100);
    check_txn("m0", 3, 32'h0020_1004, 1'b1, 32'h0000_0001);
    check_txn("m0", 4, 32'h0020_0008, 1'b0, 32'h0);
    check_txn("m0", 5, 32'h0020_1008, 1'b0, 32'h0);
    @(negedge clk_i);
    check_eq("m0_done_pulse", done_o, 1'b0);

    // Mode 1, core 1 only, non-zero exit code.
    status_val[0] = 32'h0;
    status_val[1] = 32'h8000_0005;
    start_run(1'b1, 2'b10);
    wait_done("m1", 600, cyc);
    check_eq("m1_exit1",      exit_code_o[61:31], 31'd5);
    check_eq("m1_exit0",      exit_code_o[30:0],  31'd0);
    check_eq("m1_fail",       fail_o,      1'b1);
    check_eq("m1_core_done",  core_done_o, 2'b10);
    check_eq("m1_txn_count",  log_addr.size(), 3);
    check_txn("m1", 0, 32'h0020_1000, 1'b1, 32'h1C00_0100);
    check_txn("m1", 1, 32'h0020_1004, 1'b1, 32'h0000_0001);
    check_txn("m1", 2, 32'h0020_1008, 1'b0, 32'h0);

    // Seven-cycle ready stall on the first request.
    status_val[0] = 32'h8000_0000;
    stall_seen = 0;
    unstable   = 0;
    stall_left = 7;
    start_run(1'b0, 2'b01);
    check_eq("stall_fail_cleared", fail_o, 1'b0);
    wait_done("stall", 600, cyc);
    check_eq("stall_cycles",    stall_seen, 7);
    check_eq("stall_stable",    unstable,   0);
    check_eq("stall_txn_count", log_addr.size(), 3);
    check_txn("stall", 0, 32'h0020_0000, 1'b1, 32'h1C00_0080);
    check_eq("stall_fail",      fail_o,      1'b0);
    check_eq("stall_core_done", core_done_o, 2'b01);

    // Bus error on core 0 fetch-enable write.
    err_en   = 1'b1;
    err_addr = 32'h0020_0004;
    start_run(1'b0, 2'b11);
    wait_done("err", 600, cyc);
    check_eq("err_fail",      fail_o,      1'b1);
    check_eq("err_core_done", core_done_o, 2'b00);
    repeat (5) @(negedge clk_i);
    check_eq("err_txn_count", log_addr.size(), 2);
    check_eq("err_req_idle",  req_valid_o, 1'b0);
    check_eq("err_busy",      busy_o,      1'b0);
    err_en = 1'b0;

    // Timeout: status never reports EOC.
    status_val[0] = 32'h0;
    status_val[1] = 32'h0;
    start_run(1'b0, 2'b01);
    wait_done("tmo", 700, cyc);
    check_eq("tmo_latency_window", (cyc >= 500 && cyc <= 540), 1'b1);
    check_eq("tmo_fail",      fail_o,      1'b1);
    check_eq("tmo_core_done", core_done_o, 2'b00);

    // Reset while polling, then a clean rerun.
    status_val[0] = 32'h8000_0000;
    start_run(1'b0, 2'b01);
    cyc = 0;
    while (log_addr.size() < 2 && cyc < 50) begin
      @(negedge clk_i);
      cyc++;
    end
    check_eq("mid_writes_done", log_addr.size(), 2);
    repeat (3) @(negedge clk_i);
    check_eq("mid_busy_in_wait", busy_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_eq("mid_rst_busy",      busy_o,      1'b0);
    check_eq("mid_rst_fail",      fail_o,      1'b0);
    check_eq("mid_rst_done",      done_o,      1'b0);
    check_eq("mid_rst_req_valid", req_valid_o, 1'b0);
    check_eq("mid_rst_req_addr",  req_addr_o,  '0);
    check_eq("mid_rst_req_wdata", req_wdata_o, '0);
    rst_i = 1'b0;
    @(negedge clk_i);
    start_run(1'b0, 2'b01);
    wait_done("rerun", 600, cyc);
    check_eq("rerun_fail",      fail_o,      1'b0);
    check_eq("rerun_core_done", core_done_o, 2'b01);
    check_eq("rerun_txn_count", log_addr.size(), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
